// File: rtl/stream_packer.sv
// Narrow-to-wide AXI-stream packer: UNITS words per beat, lane 0 first.
// Optional per-lane keep output enabled by STREAM_PACKER_KEEP_EN.
module stream_packer #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    UNITS      = 4,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        l_valid,
    output logic                        l_rdy,
    input  logic [DATA_WIDTH-1:0]       d_in,
    input  logic                        T_last_in,
    input  logic                        r_rdy,
    output logic                        r_valid,
    output logic [DATA_WIDTH*UNITS-1:0] d_out,
    output logic                        T_last_out
`ifdef STREAM_PACKER_KEEP_EN
    ,
    output logic [UNITS-1:0]            k_out
`endif
);

    localparam int CW = (UNITS > 1) ? $clog2(UNITS) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(UNITS - 1);

    typedef logic [UNITS-1:0][DATA_WIDTH-1:0] lanes_t;

    lanes_t        acc_q, acc_d;
    lanes_t        dout_q, dout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rvalid_q, rvalid_d;
    logic          tlast_q, tlast_d;
    logic          accept;
    logic          complete;
`ifdef STREAM_PACKER_KEEP_EN
    logic [UNITS-1:0] keep_q, keep_d;
`endif

    always_comb begin
        l_rdy    = ~rvalid_q | r_rdy;
        accept   = l_valid & l_rdy;
        complete = accept & ((cnt_q == LAST_LANE) | T_last_in);

        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        tlast_d  = tlast_q;
        rvalid_d = rvalid_q & ~r_rdy;
`ifdef STREAM_PACKER_KEEP_EN
        keep_d   = keep_q;
`endif

        if (complete) begin
            // Beat is built from the accumulator plus the word arriving now
            for (int i = 0; i < UNITS; i++) begin
                if (CW'(i) < cnt_q) begin
                    dout_d[i] = acc_q[i];
                end else if (CW'(i) == cnt_q) begin
                    dout_d[i] = d_in;
                end else begin
                    dout_d[i] = PAD_VALUE;
                end
`ifdef STREAM_PACKER_KEEP_EN
                keep_d[i] = (CW'(i) <= cnt_q);
`endif
            end
            acc_d    = {UNITS{PAD_VALUE}};
            cnt_d    = '0;
            tlast_d  = T_last_in;
            rvalid_d = 1'b1;
        end else if (accept) begin
            for (int i = 0; i < UNITS; i++) begin
                if (CW'(i) == cnt_q) begin
                    acc_d[i] = d_in;
                end
            end
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            tlast_q  <= 1'b0;
            rvalid_q <= 1'b0;
`ifdef STREAM_PACKER_KEEP_EN
            keep_q   <= '0;
`endif
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            tlast_q  <= tlast_d;
            rvalid_q <= rvalid_d;
`ifdef STREAM_PACKER_KEEP_EN
            keep_q   <= keep_d;
`endif
        end
    end

    assign r_valid    = rvalid_q;
    assign d_out      = dout_q;
    assign T_last_out = tlast_q;
`ifdef STREAM_PACKER_KEEP_EN
    assign k_out      = keep_q;
`endif

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer (UNITS=4 main instance, UNITS=1 slice).
// Reference model packs a word list into beats; handshakes tracked per cycle.
module tb_stream_packer;

    localparam int DW = 16;
    localparam int U  = 4;
    localparam int BW = DW * U;
    localparam logic [DW-1:0] PAD = '0;

    logic          clk = 1'b0;
    logic          rstn;
    logic          l_valid, T_last_in, r_rdy;
    logic [DW-1:0] d_in;
    logic          l_rdy, r_valid, T_last_out;
    logic [BW-1:0] d_out;

    logic          u1_l_valid, u1_T_last_in, u1_r_rdy;
    logic [DW-1:0] u1_d_in;
    logic          u1_l_rdy, u1_r_valid, u1_T_last_out;
    logic [DW-1:0] u1_d_out;

`ifdef STREAM_PACKER_KEEP_EN
    logic [U-1:0]  k_out;
    logic [0:0]    u1_k_out;
`endif

    stream_packer #(.DATA_WIDTH(DW), .UNITS(U), .PAD_VALUE(PAD)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .l_valid    (l_valid),
        .l_rdy      (l_rdy),
        .d_in       (d_in),
        .T_last_in  (T_last_in),
        .r_rdy      (r_rdy),
        .r_valid    (r_valid),
        .d_out      (d_out),
        .T_last_out (T_last_out)
`ifdef STREAM_PACKER_KEEP_EN
        ,
        .k_out      (k_out)
`endif
    );

    stream_packer #(.DATA_WIDTH(DW), .UNITS(1), .PAD_VALUE(PAD)) dut1 (
        .clk        (clk),
        .rstn       (rstn),
        .l_valid    (u1_l_valid),
        .l_rdy      (u1_l_rdy),
        .d_in       (u1_d_in),
        .T_last_in  (u1_T_last_in),
        .r_rdy      (u1_r_rdy),
        .r_valid    (u1_r_valid),
        .d_out      (u1_d_out),
        .T_last_out (u1_T_last_out)
`ifdef STREAM_PACKER_KEEP_EN
        ,
        .k_out      (u1_k_out)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit            m_valid;
    logic [BW-1:0] m_beat;
    bit            m_last;
    logic [U-1:0]  m_keep;
    logic [DW-1:0] part[$];

    task automatic chk(input string tag, input logic [BW-1:0] obs,
                       input logic [BW-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 0;
        m_beat  = '0;
        m_last  = 0;
        m_keep  = '0;
        part.delete();
    endtask

    // One cycle: drive, check ready, advance model, check registered outputs
    task automatic step(input bit lv, input logic [DW-1:0] d,
                        input bit tl, input bit rr);
        bit exp_rdy;
        l_valid   = lv;
        d_in      = d;
        T_last_in = tl;
        r_rdy     = rr;
        #2;
        exp_rdy = !m_valid || rr;
        chk("l_rdy", BW'(l_rdy), BW'(exp_rdy));
        if (m_valid && rr) m_valid = 0;
        if (lv && exp_rdy) begin
            part.push_back(d);
            if (part.size() == U || tl) begin
                for (int i = 0; i < U; i++) begin
                    m_beat[i*DW +: DW] = (i < part.size()) ? part[i] : PAD;
                    m_keep[i] = (i < part.size());
                end
                m_last  = tl;
                m_valid = 1;
                part.delete();
            end
        end
        @(posedge clk);
        #1;
        chk("r_valid", BW'(r_valid), BW'(m_valid));
        chk("d_out", d_out, m_beat);
        chk("T_last_out", BW'(T_last_out), BW'(m_last));
`ifdef STREAM_PACKER_KEEP_EN
        chk("k_out", BW'(k_out), BW'(m_keep));
`endif
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        l_valid   = 1'b0;
        d_in      = '0;
        T_last_in = 1'b0;
        r_rdy     = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
        chk("rst_r_valid", BW'(r_valid), '0);
        chk("rst_d_out", d_out, '0);
        chk("rst_T_last", BW'(T_last_out), '0);
`ifdef STREAM_PACKER_KEEP_EN
        chk("rst_k_out", BW'(k_out), '0);
`endif
        rstn = 1'b1;
    endtask

    initial begin
        u1_l_valid   = 1'b0;
        u1_d_in      = '0;
        u1_T_last_in = 1'b0;
        u1_r_rdy     = 1'b1;
        do_reset();

        // Full beats, words 1..8
        for (int w = 1; w <= 8; w++) begin
            step(1, DW'(w), w == 8, 1);
            if (w == 4) chk("beat0", d_out, 64'h0004_0003_0002_0001);
            if (w == 8) chk("beat1", d_out, 64'h0008_0007_0006_0005);
        end

        // Partial last beat
        step(1, 16'hAAAA, 0, 1);
        step(1, 16'hBBBB, 1, 1);
        chk("partial", d_out, 64'h0000_0000_BBBB_AAAA);
`ifdef STREAM_PACKER_KEEP_EN
        chk("partial_keep", BW'(k_out), BW'(4'b0011));
`endif

        // Backpressure
        for (int w = 0; w < 4; w++) step(1, DW'(16'h0021 + w), 0, 1);
        for (int c = 0; c < 5; c++) begin
            step(1, 16'h0025, 0, 0);
            chk("stall_hold", d_out, 64'h0024_0023_0022_0021);
        end
        for (int w = 0; w < 4; w++) step(1, DW'(16'h0025 + w), w == 3, 1);
        chk("after_stall", d_out, 64'h0028_0027_0026_0025);

        // Reset mid-packet
        step(1, 16'h00E1, 0, 1);
        step(1, 16'h00E2, 0, 1);
        do_reset();
        for (int w = 0; w < 4; w++) step(1, DW'(16'h0011 + w), 0, 1);
        chk("post_reset", d_out, 64'h0014_0013_0012_0011);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, DW'($urandom),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
        end
        for (int n = 0; n < 2; n++) step(0, '0, 0, 1);

        // UNITS=1 register slice
        u1_l_valid = 1'b1; u1_d_in = 16'h1234; u1_T_last_in = 1'b0;
        step(0, '0, 0, 1);
        chk("u1_valid0", BW'(u1_r_valid), BW'(1'b1));
        chk("u1_data0", BW'(u1_d_out), BW'(16'h1234));
        chk("u1_last0", BW'(u1_T_last_out), BW'(1'b0));
        u1_d_in = 16'h5678; u1_T_last_in = 1'b1;
        step(0, '0, 0, 1);
        chk("u1_valid1", BW'(u1_r_valid), BW'(1'b1));
        chk("u1_data1", BW'(u1_d_out), BW'(16'h5678));
        chk("u1_last1", BW'(u1_T_last_out), BW'(1'b1));
        u1_l_valid = 1'b0; u1_T_last_in = 1'b0;
        step(0, '0, 0, 1);
        chk("u1_drain", BW'(u1_r_valid), BW'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
